an3_serial_encoder: RTL
=======================

// Module: an3_serial_encoder
// PURPOSE
//  Transmit side of the 3N (AN, A=3) arithmetic code used by the divisible-by-3 checker.
//  - Accepts a DATA_W-bit data word on a valid/ready handshake.
//  - Forms codeword = 3*data with a bit-serial adder (data + data<<1).
//  - Shifts the codeword out LSB-first, one bit per clock.
//  - Presents the completed CODE_W-bit word in parallel so the combinational checker
//    can confirm divisibility.
// PARAMETERS
//  DATA_W   14           data word width; 3*(2^DATA_W-1) must fit in CODE_W
//  CODE_W   DATA_W+2     codeword width (localparam, derived, not overridable)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       reset; synchronous, active-high
//  in_valid    in   1       in_data valid
//  in_ready    out  1       block can accept a word this cycle
//  in_data     in   DATA_W  word to encode
//  tx_bit      out  1       serial codeword bit, LSB first
//  tx_valid    out  1       tx_bit valid
//  tx_first    out  1       tx_bit is codeword bit 0
//  tx_last     out  1       tx_bit is codeword bit CODE_W-1
//  code_word   out  CODE_W  last completed codeword, held until the next completes
//  code_valid  out  1       one-cycle pulse: code_word just updated
// BEHAVIOUR
//  - Reset values: in_ready=0 while rst=1; tx_bit, tx_valid, tx_first, tx_last,
//    code_valid=0; code_word=0; state IDLE; carry=0; bit count=0.
//  - FSM IDLE -> SHIFT on accept (in_valid & in_ready).
//    SHIFT -> IDLE after bit CODE_W-1, unless a new word is accepted that same cycle;
//    then the FSM stays in SHIFT and restarts at bit 0.
//  - in_ready: 1 in IDLE; 1 in SHIFT only during the tx_last cycle; 0 otherwise.
//    Combinational from state and count only. No tx-side backpressure exists.
//  - Latency: word accepted at edge k -> bit i driven in cycle k+1+i, i=0..CODE_W-1.
//    Back-to-back words produce no idle cycle between frames.
//  - Serial arithmetic, d_-1=0 and d_j=0 for j>=DATA_W:
//      tx_bit_i = d_i ^ d_(i-1) ^ c
//      c'       = maj(d_i, d_(i-1), c)
//    Carry clears at each frame start. Final carry is always 0 (fits CODE_W by construction).
//  - code_word assembles the transmitted bits. It updates and code_valid pulses in the
//    cycle after tx_last. That cycle may coincide with tx_first of the next frame.
//  - in_valid while in_ready=0: ignored. The upstream source holds in_data stable.
//  - rst mid-frame: frame discarded, no code_valid pulse, tx_valid=0 from the next cycle.
//    code_word keeps reset value 0.
// CONFIGURATION
//  AN3_ERR_INJ_EN defined:
//    - Adds port err_inj (in, 1), sampled with in_data on accept.
//    - When set, codeword bit 0 is inverted on tx_bit and in code_word. The result is
//      never divisible by 3 and is used to exercise the checker.
//  AN3_ERR_INJ_EN undefined: no err_inj port; codeword is always exactly 3*data.
// STRUCTURE
//  - Package an3_pkg: DATA_W/CODE_W defaults, state enum {IDLE, SHIFT},
//    bit-count width $clog2(CODE_W).
//  - Sub-module an3_serial_adder_bit: 1-bit full adder + carry flop, with a clear input
//    for frame start.
//  - Top: FSM, data shift register, previous-bit flop, counter, code_word assembly.
// TESTING
//  1 rst, in_data=14'd5 -> tx_bit LSB-first 1,1,1,1,0x12; code_word=16'h000F, code_valid 1 cycle.
//  2 in_data=14'h3FFF -> code_word=16'hBFFD; no carry lost at bit 15.
//  3 words 1 then 2 back-to-back (2 accepted on tx_last) -> 16'h0003 then 16'h0006, no gap.
//  4 rst at bit 7 of in_data=14'd100 -> tx_valid=0 next cycle, no code_valid;
//    next word 7 -> 16'h0015.
//  5 in_valid held during frame -> in_ready low until tx_last; held word accepted there,
//    encoded correctly.
//  6 AN3_ERR_INJ_EN, err_inj=1, in_data=5 -> code_word=16'h000E; checker flags
//    not divisible.

Source files
------------

// File: rtl/an3_pkg.sv
// Shared defaults and types for the 3N (AN, A=3) serial encoder.
package an3_pkg;

    localparam int DATA_W_DEF = 14;
    localparam int CODE_W_DEF = DATA_W_DEF + 2;
    localparam int CNT_W_DEF  = $clog2(CODE_W_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-count width for a codeword of code_w bits, never narrower than 1.
    function automatic int cnt_w(input int code_w);
        return (code_w > 1) ? $clog2(code_w) : 1;
    endfunction

endpackage

// File: rtl/an3_serial_adder_bit.sv
// One-bit serial full adder: combinational sum, registered carry cleared at frame start.
module an3_serial_adder_bit (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic clr,
    input  logic en,
    output logic sum
);

    logic carry_reg;
    logic carry_next;

    assign sum = a ^ b ^ carry_reg;

    always_comb begin
        carry_next = carry_reg;
        if (clr) begin
            carry_next = 1'b0;
        end else if (en) begin
            carry_next = (a & b) | (a & carry_reg) | (b & carry_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= carry_next;
        end
    end

endmodule

// File: rtl/an3_serial_encoder.sv
// 3N arithmetic-code transmitter: serialises 3*data LSB-first and publishes the full codeword.
// Optional AN3_ERR_INJ_EN adds err_inj, which inverts codeword bit 0 for checker exercise.
module an3_serial_encoder
    import an3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
`ifdef AN3_ERR_INJ_EN
    input  logic                err_inj,
`endif
    output logic                tx_bit,
    output logic                tx_valid,
    output logic                tx_first,
    output logic                tx_last,
    output logic [DATA_W+1:0]   code_word,
    output logic                code_valid
);

    localparam int CODE_W = DATA_W + 2;
    localparam int CNT_W  = cnt_w(CODE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_W - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_W-1:0]   data_reg;
    logic                prev_reg;
    logic [CODE_W-1:0]   asm_reg;
    logic [CODE_W-1:0]   code_word_reg;
    logic                code_valid_reg;
    logic                shifting;
    logic                last;
    logic                accept;
    logic                sum;
    logic                flip;
    logic                bit_out;

    assign shifting = (state_reg == SHIFT);
    assign last     = shifting && (cnt_reg == LAST_CNT);
    // A new word may only enter while idle or on the final bit of the current frame.
    assign in_ready = ~rst & (~shifting | last);
    assign accept   = in_valid & in_ready;

    an3_serial_adder_bit u_adder (
        .clk (clk),
        .rst (rst),
        .a   (data_reg[0]),
        .b   (prev_reg),
        .clr (accept),
        .en  (shifting),
        .sum (sum)
    );

`ifdef AN3_ERR_INJ_EN
    logic err_reg;
    assign flip = err_reg & (cnt_reg == '0);
`else
    assign flip = 1'b0;
`endif

    assign bit_out    = sum ^ flip;
    assign tx_bit     = shifting & bit_out;
    assign tx_valid   = shifting;
    assign tx_first   = shifting && (cnt_reg == '0);
    assign tx_last    = last;
    assign code_word  = code_word_reg;
    assign code_valid = code_valid_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (accept) begin
                    cnt_next = '0;
                end else if (last) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            data_reg       <= '0;
            prev_reg       <= 1'b0;
            asm_reg        <= '0;
            code_word_reg  <= '0;
            code_valid_reg <= 1'b0;
`ifdef AN3_ERR_INJ_EN
            err_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            code_valid_reg <= last;
            if (last) begin
                code_word_reg <= {bit_out, asm_reg[CODE_W-1:1]};
            end
            if (shifting) begin
                asm_reg <= {bit_out, asm_reg[CODE_W-1:1]};
            end
            // Shifting in zeros supplies d_j = 0 for the two top codeword bits.
            if (accept) begin
                data_reg <= in_data;
                prev_reg <= 1'b0;
`ifdef AN3_ERR_INJ_EN
                err_reg  <= err_inj;
`endif
            end else if (shifting) begin
                data_reg <= {1'b0, data_reg[DATA_W-1:1]};
                prev_reg <= data_reg[0];
            end
        end
    end

endmodule
